// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for a 5-stage core: keeps destination tags of the E/M/W
// instructions and derives per-operand forwarding selects plus stall/flush controls.

module hazard_fwd_lane #(
    parameter int NWB = 2,
    parameter int AW  = 4,
    parameter int FW  = 3
) (
    input  logic                   sv,
    input  logic [AW-1:0]          src,
    input  logic [NWB-1:0][AW-1:0] m_dst,
    input  logic [NWB-1:0]         m_dv,
    input  logic [NWB-1:0][AW-1:0] w_dst,
    input  logic [NWB-1:0]         w_dv,
    output logic [FW-1:0]          fwd
);
    localparam logic [AW-1:0] PC = '1;

    always_comb begin
        fwd = '0;
        if (sv && src != PC) begin
            // Farthest candidate first, so nearest stage / lowest port overwrites last.
            for (int k = NWB-1; k >= 0; k--)
                if (w_dv[k] && w_dst[k] == src) fwd = FW'(1 + NWB + k);
            for (int k = NWB-1; k >= 0; k--)
                if (m_dv[k] && m_dst[k] == src) fwd = FW'(1 + k);
        end
    end
endmodule

module hazard_scoreboard #(
    parameter int NSRC     = 4,
    parameter int NWB      = 2,
    parameter int AW       = 4,
    parameter int LONG_LAT = 3,
    parameter int FW       = $clog2(1 + 2*NWB)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NSRC*AW-1:0] src_d,
    input  logic [NSRC-1:0]    src_valid_d,
    input  logic [NWB*AW-1:0]  dst_d,
    input  logic [NWB-1:0]     dst_valid_d,
    input  logic               load_d,
    input  logic               long_d,
    input  logic               pcwr_d,
    input  logic               cond_fail_e,
    input  logic               branch_taken_e,
    output logic [NSRC*FW-1:0] fwd_e,
    output logic               stall_f,
    output logic               stall_d,
    output logic               stall_e,
    output logic               flush_d,
    output logic               flush_e,
    output logic               long_busy
);
    localparam logic [AW-1:0] PC = '1;
    localparam int CW = (LONG_LAT > 1) ? $clog2(LONG_LAT) : 1;

    logic [NSRC-1:0][AW-1:0] d_src;
    logic [NWB-1:0][AW-1:0]  d_dst;
    assign d_src = src_d;
    assign d_dst = dst_d;

    logic [NSRC-1:0][AW-1:0] e_src;
    logic [NSRC-1:0]         e_sv;
    logic [NWB-1:0][AW-1:0]  e_dst, m_dst, w_dst;
    logic [NWB-1:0]          e_dv, m_dv, w_dv;
    logic                    e_load, e_long, e_pcwr, m_pcwr;
    logic [CW-1:0]           cnt;
    logic                    load_use, pc_pend, br;

    always_comb begin
        load_use = 1'b0;
        for (int i = 0; i < NSRC; i++)
            if (src_valid_d[i] && d_src[i] != PC && e_load && e_dv[0] && e_dst[0] == d_src[i])
                load_use = 1'b1;
    end

    assign long_busy = e_long && (cnt != '0);
    assign stall_e   = long_busy;
    assign pc_pend   = pcwr_d || e_pcwr || m_pcwr;
    // A held E stage cannot resolve a branch, so the redirect is ignored then.
    assign br        = branch_taken_e && !long_busy;

    always_comb begin
        stall_f = long_busy || load_use || pc_pend;
        stall_d = long_busy || load_use;
        flush_d = pc_pend;
        flush_e = load_use && !long_busy;
        if (br) begin
            stall_f = 1'b0;
            stall_d = 1'b0;
            flush_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_src  <= '0;
            e_sv   <= '0;
            e_dst  <= '0;
            e_dv   <= '0;
            e_load <= 1'b0;
            e_long <= 1'b0;
            e_pcwr <= 1'b0;
            m_dst  <= '0;
            m_dv   <= '0;
            m_pcwr <= 1'b0;
            w_dst  <= '0;
            w_dv   <= '0;
            cnt    <= '0;
        end else begin
            if (!stall_e) begin
                if (flush_e) begin
                    e_src  <= '0;
                    e_sv   <= '0;
                    e_dst  <= '0;
                    e_dv   <= '0;
                    e_load <= 1'b0;
                    e_long <= 1'b0;
                    e_pcwr <= 1'b0;
                end else begin
                    e_src  <= d_src;
                    e_sv   <= src_valid_d;
                    e_dst  <= d_dst;
                    e_dv   <= dst_valid_d;
                    e_load <= load_d;
                    e_long <= long_d;
                    e_pcwr <= pcwr_d;
                end
            end
            // A condition-failed instruction carries no writes down the pipe.
            if (stall_e) begin
                m_dv   <= '0;
                m_pcwr <= 1'b0;
            end else begin
                m_dst  <= e_dst;
                m_dv   <= cond_fail_e ? '0 : e_dv;
                m_pcwr <= e_pcwr && !cond_fail_e;
            end
            w_dst <= m_dst;
            w_dv  <= m_dv;
            if (!stall_e && !flush_e && long_d)
                cnt <= CW'(LONG_LAT - 1);
            else if (long_busy)
                cnt <= cnt - 1'b1;
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_lane
        hazard_fwd_lane #(.NWB(NWB), .AW(AW), .FW(FW)) u_lane (
            .sv    (e_sv[i]),
            .src   (e_src[i]),
            .m_dst (m_dst),
            .m_dv  (m_dv),
            .w_dst (w_dst),
            .w_dv  (w_dv),
            .fwd   (fwd_e[i*FW +: FW])
        );
    end
endmodule
